// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM read arbiter.
package sdram_arb_pkg;
  localparam int unsigned DEF_MAX_OUTSTANDING = 8;
  localparam int unsigned DEF_STARVE_LIMIT    = 16;

  localparam logic PORT_DISPLAY = 1'b0;
  localparam logic PORT_GENERAL = 1'b1;

  typedef struct packed {
    logic       port;
    logic [7:0] burstcount;
  } tag_t;

  // A zero burstcount still returns one beat, so it is tracked as a length of one.
  function automatic logic [7:0] tag_len(input logic [7:0] bc);
    return (bc == 8'd0) ? 8'd1 : bc;
  endfunction
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Register FIFO holding the owner and length of every outstanding burst.
// A push is accepted while full only when a pop happens in the same cycle.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  tag_t        push_tag_i,
  input  logic        pop_i,
  output tag_t        head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  tag_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sdram_read_arbiter.sv
// Two-master arbiter for the 64-bit Avalon-MM SDRAM read port: display port 0 has
// priority, port 1 is forced through after STARVE_LIMIT waits. SDRAM_ARB_STATS_EN adds stat_* outputs.
module sdram_read_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [28:0] m0_address,
  input  logic [7:0]  m0_burstcount,
  input  logic        m0_read,
  output logic        m0_waitrequest,
  output logic [63:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [28:0] m1_address,
  input  logic [7:0]  m1_burstcount,
  input  logic        m1_read,
  output logic        m1_waitrequest,
  output logic [63:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [28:0] sdram_address,
  output logic [7:0]  sdram_burstcount,
  output logic        sdram_read,
  input  logic        sdram_waitrequest,
  input  logic [63:0] sdram_readdata,
  input  logic        sdram_readdatavalid,
  output logic        protocol_error
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [31:0] stat_grants0,
  output logic [31:0] stat_grants1,
  output logic [7:0]  stat_max_outstanding,
  output logic [15:0] stat_starve_forces
`endif
);
  localparam int unsigned AW    = $clog2(MAX_OUTSTANDING);
  localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);

  logic [28:0] addr_q;
  logic [7:0]  bc_q, beat_q, starve_q;
  logic        read_q, perr_q;
  tag_t        head, push_tag;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        slot_free, can_issue, beat_ok, pop, grant0, grant1, push;

  assign beat_ok   = sdram_readdatavalid && !fifo_empty;
  assign pop       = beat_ok && (beat_q == head.burstcount - 8'd1);
  assign slot_free = !read_q || !sdram_waitrequest;
  // Post-pop occupancy: a completing burst frees its slot for this cycle's capture.
  assign can_issue = slot_free && (!fifo_full || pop);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_issue) begin
      if (m1_read && (!m0_read || starve_q == LIMIT)) grant1 = 1'b1;
      else if (m0_read)                               grant0 = 1'b1;
    end
  end

  assign push     = grant0 || grant1;
  assign push_tag = '{port:       grant1 ? PORT_GENERAL : PORT_DISPLAY,
                      burstcount: tag_len(grant1 ? m1_burstcount : m0_burstcount)};

  sdram_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_tag_i (push_tag),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      read_q   <= 1'b0;
      addr_q   <= '0;
      bc_q     <= '0;
      beat_q   <= '0;
      starve_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      if (slot_free) begin
        read_q <= push;
        if (push) begin
          addr_q <= grant1 ? m1_address    : m0_address;
          bc_q   <= grant1 ? m1_burstcount : m0_burstcount;
        end
      end
      if (beat_ok) beat_q <= pop ? 8'd0 : beat_q + 8'd1;
      if (sdram_readdatavalid && fifo_empty) perr_q <= 1'b1;
      if (!m1_read || grant1)                     starve_q <= '0;
      else if (grant0 && starve_q != LIMIT)       starve_q <= starve_q + 8'd1;
    end
  end

  assign sdram_read       = read_q;
  assign sdram_address    = addr_q;
  assign sdram_burstcount = bc_q;
  assign protocol_error   = perr_q;

  assign m0_waitrequest   = !grant0;
  assign m1_waitrequest   = !grant1;
  assign m0_readdata      = sdram_readdata;
  assign m1_readdata      = sdram_readdata;
  assign m0_readdatavalid = beat_ok && (head.port == PORT_DISPLAY);
  assign m1_readdatavalid = beat_ok && (head.port == PORT_GENERAL);

`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] g0_q, g1_q;
  logic [7:0]  max_q;
  logic [15:0] forces_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      g0_q     <= '0;
      g1_q     <= '0;
      max_q    <= '0;
      forces_q <= '0;
    end else begin
      if (grant0 && g0_q != '1) g0_q <= g0_q + 32'd1;
      if (grant1 && g1_q != '1) g1_q <= g1_q + 32'd1;
      if (grant1 && m0_read && starve_q == LIMIT && forces_q != '1) forces_q <= forces_q + 16'd1;
      if (8'(fifo_count) > max_q) max_q <= 8'(fifo_count);
    end
  end

  assign stat_grants0         = g0_q;
  assign stat_grants1         = g1_q;
  assign stat_max_outstanding = max_q;
  assign stat_starve_forces   = forces_q;
`else
  // Occupancy is only observed by the statistics block.
  logic unused_count;
  assign unused_count = ^fifo_count;
`endif
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed and randomized bench for sdram_read_arbiter against a queue-based reference model.
module tb_sdram_read_arbiter;
  localparam int MAX_OUT = 4;
  localparam int LIMIT   = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [28:0] m0_address, m1_address;
  logic [7:0]  m0_burstcount, m1_burstcount;
  logic        m0_read, m1_read;
  logic        m0_waitrequest, m1_waitrequest;
  logic [63:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [28:0] sdram_address;
  logic [7:0]  sdram_burstcount;
  logic        sdram_read, sdram_waitrequest;
  logic [63:0] sdram_readdata;
  logic        sdram_readdatavalid;
  logic        protocol_error;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] stat_grants0, stat_grants1;
  logic [7:0]  stat_max_outstanding;
  logic [15:0] stat_starve_forces;
`endif

  always #5 clock = ~clock;

  sdram_read_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
    .clock               (clock),
    .reset               (reset),
    .m0_address          (m0_address),
    .m0_burstcount       (m0_burstcount),
    .m0_read             (m0_read),
    .m0_waitrequest      (m0_waitrequest),
    .m0_readdata         (m0_readdata),
    .m0_readdatavalid    (m0_readdatavalid),
    .m1_address          (m1_address),
    .m1_burstcount       (m1_burstcount),
    .m1_read             (m1_read),
    .m1_waitrequest      (m1_waitrequest),
    .m1_readdata         (m1_readdata),
    .m1_readdatavalid    (m1_readdatavalid),
    .sdram_address       (sdram_address),
    .sdram_burstcount    (sdram_burstcount),
    .sdram_read          (sdram_read),
    .sdram_waitrequest   (sdram_waitrequest),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .protocol_error      (protocol_error)
`ifdef SDRAM_ARB_STATS_EN
    ,
    .stat_grants0         (stat_grants0),
    .stat_grants1         (stat_grants1),
    .stat_max_outstanding (stat_max_outstanding),
    .stat_starve_forces   (stat_starve_forces)
`endif
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Reference model: outstanding bursts as a queue of (owner, beats), plus expected command.
  int          q_port[$];
  int          q_len[$];
  int          beats_done;
  int          starve;
  bit          exp_read, exp_perr;
  logic [28:0] exp_addr;
  logic [7:0]  exp_bc;
  longint      g0, g1, forces;
  int          maxocc;

  int last_grant, last_valid;
  bit auto_ret;
  int ret_pct;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_port.delete();
    q_len.delete();
    beats_done = 0;
    starve     = 0;
    exp_read   = 1'b0;
    exp_perr   = 1'b0;
    exp_addr   = '0;
    exp_bc     = '0;
    g0 = 0; g1 = 0; forces = 0; maxocc = 0;
  endtask

  task automatic cycle();
    int win, exp_vport, occ_after, len;
    bit slot_free, pop_now, can_issue;
    if (auto_ret) sdram_readdatavalid = (q_port.size() > 0) && ($urandom_range(99) < ret_pct);
    sdram_readdata = {$urandom, $urandom};
    @(negedge clock);
    last_grant = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
    last_valid = m0_readdatavalid ? 0 : (m1_readdatavalid ? 1 : -1);
    if (reset) model_reset();
    else begin
      slot_free = !exp_read || !sdram_waitrequest;
      pop_now   = sdram_readdatavalid && q_port.size() > 0 && (beats_done + 1 == q_len[0]);
      occ_after = q_port.size() - int'(pop_now);
      can_issue = slot_free && occ_after < MAX_OUT;
      win = -1;
      if (can_issue) begin
        if (m1_read && (!m0_read || starve == LIMIT)) win = 1;
        else if (m0_read) win = 0;
      end
      exp_vport = (sdram_readdatavalid && q_port.size() > 0) ? q_port[0] : -1;
      chk("m0_waitrequest",   m0_waitrequest,   win != 0);
      chk("m1_waitrequest",   m1_waitrequest,   win != 1);
      chk("m0_readdatavalid", m0_readdatavalid, exp_vport == 0);
      chk("m1_readdatavalid", m1_readdatavalid, exp_vport == 1);
      chk("m0_readdata",      m0_readdata,      sdram_readdata);
      chk("m1_readdata",      m1_readdata,      sdram_readdata);
      chk("sdram_read",       sdram_read,       exp_read);
      chk("sdram_address",    sdram_address,    exp_addr);
      chk("sdram_burstcount", sdram_burstcount, exp_bc);
      chk("protocol_error",   protocol_error,   exp_perr);
`ifdef SDRAM_ARB_STATS_EN
      chk("stat_grants0",         stat_grants0,         32'(g0));
      chk("stat_grants1",         stat_grants1,         32'(g1));
      chk("stat_max_outstanding", stat_max_outstanding, 8'(maxocc));
      chk("stat_starve_forces",   stat_starve_forces,   16'(forces));
`endif
      if (q_port.size() > maxocc) maxocc = q_port.size();
      if (win == 0) g0++;
      if (win == 1) g1++;
      if (win == 1 && m0_read && starve == LIMIT) forces++;
      if (sdram_readdatavalid) begin
        if (q_port.size() == 0) exp_perr = 1'b1;
        else begin
          beats_done++;
          if (beats_done == q_len[0]) begin
            void'(q_port.pop_front());
            void'(q_len.pop_front());
            beats_done = 0;
          end
        end
      end
      if (slot_free) begin
        exp_read = (win >= 0);
        if (win >= 0) begin
          exp_addr = (win == 1) ? m1_address : m0_address;
          exp_bc   = (win == 1) ? m1_burstcount : m0_burstcount;
          len      = (exp_bc == 8'd0) ? 1 : int'(exp_bc);
          q_port.push_back(win);
          q_len.push_back(len);
        end
      end
      if (!m1_read || win == 1) starve = 0;
      else if (win == 0 && starve < LIMIT) starve++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m1_read = 1'b0;
    sdram_waitrequest = 1'b0; sdram_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    auto_ret = 1'b0;
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  initial begin
    int n0, n1;
    int grants[8];
    int exp_seq[8];
    int vlog[$];
    int exp_route[6];
    exp_seq   = '{0, 0, 0, 1, 0, 0, 0, 1};
    exp_route = '{0, 0, 1, 1, 1, 0};
    m0_address = '0; m1_address = '0; m0_burstcount = '0; m1_burstcount = '0;
    sdram_readdata = '0; ret_pct = 100;
    idle();
    model_reset();
    do_reset();

    // Port 1 alone, burst of 4 at 0x100
    m1_read = 1'b1; m1_address = 29'h100; m1_burstcount = 8'd4;
    cycle();
    chk("s1_grant", 64'(last_grant), 64'(1));
    chk("s1_sdram_read", sdram_read, 1'b1);
    chk("s1_sdram_address", sdram_address, 29'h100);
    m1_read = 1'b0;
    n0 = 0; n1 = 0;
    sdram_readdatavalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (last_valid == 0) n0++;
      if (last_valid == 1) n1++;
    end
    sdram_readdatavalid = 1'b0;
    cycle();
    chk("s1_m1_beats", 64'(n1), 64'(4));
    chk("s1_m0_beats", 64'(n0), 64'(0));

    // Both request every cycle: starvation relief every fourth grant
    do_reset();
    m0_read = 1'b1; m0_address = 29'h2000; m0_burstcount = 8'd1;
    m1_read = 1'b1; m1_address = 29'h3000; m1_burstcount = 8'd1;
    auto_ret = 1'b1; ret_pct = 100;
    for (int i = 0; i < 8; i++) begin
      cycle();
      grants[i] = last_grant;
    end
    for (int i = 0; i < 8; i++) chk("s2_grant_seq", 64'(grants[i]), 64'(exp_seq[i]));
`ifdef SDRAM_ARB_STATS_EN
    chk("s2_starve_forces", stat_starve_forces, 16'd2);
    chk("s2_grants0", stat_grants0, 32'd6);
    chk("s2_grants1", stat_grants1, 32'd2);
`endif
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (4) cycle();
    auto_ret = 1'b0;

    // Interleaved outstanding bursts m0(2), m1(3), m0(1)
    do_reset();
    m0_read = 1'b1; m0_address = 29'h10; m0_burstcount = 8'd2;
    cycle(); chk("s3_grant_a", 64'(last_grant), 64'(0));
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 29'h20; m1_burstcount = 8'd3;
    cycle(); chk("s3_grant_b", 64'(last_grant), 64'(1));
    m1_read = 1'b0; m0_read = 1'b1; m0_address = 29'h30; m0_burstcount = 8'd1;
    cycle(); chk("s3_grant_c", 64'(last_grant), 64'(0));
    m0_read = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sdram_readdatavalid = (i % 2 == 0);
      cycle();
      if (last_valid >= 0) vlog.push_back(last_valid);
    end
    sdram_readdatavalid = 1'b0;
    chk("s3_route_count", 64'(vlog.size()), 64'(6));
    for (int i = 0; i < 6 && i < vlog.size(); i++) chk("s3_route", 64'(vlog[i]), 64'(exp_route[i]));
    // FIFO now empty: a stray beat must be dropped and flagged
    sdram_readdatavalid = 1'b1;
    cycle();
    chk("s6_stray_no_valid", 64'(last_valid), 64'(-1));
    sdram_readdatavalid = 1'b0;
    repeat (3) cycle();
    chk("s6_perr_sticky", protocol_error, 1'b1);

    // Reset mid-burst, then late beat
    do_reset();
    chk("s6_perr_cleared", protocol_error, 1'b0);
    m0_read = 1'b1; m0_address = 29'h40; m0_burstcount = 8'd4;
    cycle();
    m0_read = 1'b0; sdram_readdatavalid = 1'b1;
    cycle();
    do_reset();
    sdram_readdatavalid = 1'b1;
    cycle();
    chk("s6_late_no_valid", 64'(last_valid), 64'(-1));
    sdram_readdatavalid = 1'b0;
    cycle();
    chk("s6_late_perr", protocol_error, 1'b1);

    // Command hold while SDRAM stalls
    do_reset();
    m0_read = 1'b1; m0_address = 29'h1234; m0_burstcount = 8'd5;
    cycle();
    sdram_waitrequest = 1'b1;
    m0_address = 29'h555; m0_burstcount = 8'd7;
    m1_read = 1'b1; m1_address = 29'h777; m1_burstcount = 8'd2;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("s4_hold_addr", sdram_address, 29'h1234);
      chk("s4_hold_bc", sdram_burstcount, 8'd5);
      chk("s4_hold_read", sdram_read, 1'b1);
      chk("s4_no_grant", 64'(last_grant), 64'(-1));
    end
    idle();
    cycle();

    // Tag FIFO full: fifth request stalls until a burst completes
    do_reset();
    for (int i = 0; i < MAX_OUT; i++) begin
      m0_read = 1'b1; m0_address = 29'(i + 1); m0_burstcount = 8'd2;
      cycle();
      chk("s5_fill_grant", 64'(last_grant), 64'(0));
    end
    m0_address = 29'h99;
    cycle();
    chk("s5_full_stall", 64'(last_grant), 64'(-1));
    sdram_readdatavalid = 1'b1;
    cycle();
    chk("s5_partial_stall", 64'(last_grant), 64'(-1));
    cycle();
    chk("s5_pop_push_grant", 64'(last_grant), 64'(0));
    chk("s5_captured_addr", sdram_address, 29'h99);
    idle();
    cycle();

    // Randomized traffic against the model
    do_reset();
    auto_ret = 1'b1; ret_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      m0_read = ($urandom_range(99) < 50);
      m1_read = ($urandom_range(99) < 60);
      m0_address = 29'($urandom); m1_address = 29'($urandom);
      m0_burstcount = 8'($urandom_range(4)); m1_burstcount = 8'($urandom_range(4));
      sdram_waitrequest = ($urandom_range(99) < 30);
      cycle();
    end
    idle();
    repeat (40) cycle();
    chk("rand_drained_no_perr", protocol_error, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
